// File: rtl/mod_port.sv
// mod_port: buffers 64-bit packet words in a FIFO and frames them onto XGMII TX.
// Define MOD_PORT_STATS_EN to add the tx_pkt_count transmitted-packet counter.
module mod_port #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic [63:0] pkt_tx_data,
  input  logic        pkt_tx_val,
  input  logic        pkt_tx_sop,
  input  logic        pkt_tx_eop,
  input  logic [2:0]  pkt_tx_mod,
  output logic        pkt_tx_full,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc
`ifdef MOD_PORT_STATS_EN
  ,
  output logic [31:0] tx_pkt_count
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_D  = 64'h07070707070707FD;

  typedef logic [AW:0] ptr_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    TERM,
    IPG
  } state_t;

  entry_t mem [FIFO_DEPTH];
  ptr_t   wr_ptr, rd_ptr, occ, occ_next, pkt_cnt;
  logic   fifo_full, fifo_empty, wr_en, pop, eop_wr_q;
  entry_t head;

  state_t      state_q, state_d;
  logic [71:0] col_d;

  assign occ        = wr_ptr - rd_ptr;
  assign fifo_full  = (occ == ptr_t'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);
  assign wr_en      = pkt_tx_val && !fifo_full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign occ_next   = occ + ptr_t'(wr_en) - ptr_t'(pop);

  always_ff @(posedge clk_156m25) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= '{data: pkt_tx_data, sop: pkt_tx_sop,
                               eop: pkt_tx_eop, mod: pkt_tx_mod};
  end

  // The complete-packet count lags the eop write by one cycle so a packet
  // is only launched once its last word has settled in the FIFO.
  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pkt_cnt     <= '0;
      eop_wr_q    <= 1'b0;
      pkt_tx_full <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)   rd_ptr <= rd_ptr + ptr_t'(1);
      eop_wr_q    <= wr_en && pkt_tx_eop;
      pkt_cnt     <= pkt_cnt + ptr_t'(eop_wr_q) - ptr_t'(pop && head.eop);
      pkt_tx_full <= (occ_next >= ptr_t'(FIFO_DEPTH - FULL_MARGIN));
    end
  end

  function automatic logic [71:0] encode(input entry_t e);
    logic [63:0] d;
    logic [7:0]  c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      d[8*i +: 8] = e.data[63-8*i -: 8];
    end
    if (e.eop && (e.mod != 3'd0)) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (i == 32'(e.mod)) begin
          d[8*i +: 8] = 8'hFD;
          c[i]        = 1'b1;
        end else if (i > 32'(e.mod)) begin
          d[8*i +: 8] = 8'h07;
          c[i]        = 1'b1;
        end
      end
    end
    return {c, d};
  endfunction

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    col_d   = {8'hFF, IDLE_D};
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (!head.sop) begin
            pop = 1'b1;
          end else if (pkt_cnt != '0) begin
            state_d = START;
            col_d   = {8'h01, START_D};
          end
        end
      end
      // START pops the first word so data follows the start column directly.
      START, DATA: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          col_d = encode(head);
          if (head.eop) state_d = (head.mod == 3'd0) ? TERM : IPG;
          else          state_d = DATA;
        end
      end
      TERM: begin
        col_d   = {8'hFF, TERM_D};
        state_d = IPG;
      end
      IPG:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      state_q   <= IDLE;
      xgmii_txd <= IDLE_D;
      xgmii_txc <= 8'hFF;
    end else begin
      state_q   <= state_d;
      xgmii_txd <= col_d[63:0];
      xgmii_txc <= col_d[71:64];
    end
  end

`ifdef MOD_PORT_STATS_EN
  logic eop_tx;
  assign eop_tx = pop && head.eop && (state_q != IDLE);

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25)  tx_pkt_count <= '0;
    else if (eop_tx)   tx_pkt_count <= tx_pkt_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mod_port.sv
// Testbench for mod_port: directed framing/latency/full/reset checks plus a
// randomized packet stream compared against a byte-level framing model.
`timescale 1ns/1ps
module tb_mod_port;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_D  = 64'h07070707070707FD;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25 = 1'b1;
  logic [63:0] pkt_tx_data = '0;
  logic        pkt_tx_val = 1'b0;
  logic        pkt_tx_sop = 1'b0;
  logic        pkt_tx_eop = 1'b0;
  logic [2:0]  pkt_tx_mod = '0;
  logic        pkt_tx_full;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
`ifdef MOD_PORT_STATS_EN
  logic [31:0] tx_pkt_count;
`endif

  mod_port #(.FIFO_DEPTH(16), .FULL_MARGIN(2)) dut (
    .clk_156m25   (clk_156m25),
    .reset_156m25 (reset_156m25),
    .pkt_tx_data  (pkt_tx_data),
    .pkt_tx_val   (pkt_tx_val),
    .pkt_tx_sop   (pkt_tx_sop),
    .pkt_tx_eop   (pkt_tx_eop),
    .pkt_tx_mod   (pkt_tx_mod),
    .pkt_tx_full  (pkt_tx_full),
    .xgmii_txd    (xgmii_txd),
    .xgmii_txc    (xgmii_txc)
`ifdef MOD_PORT_STATS_EN
    ,
    .tx_pkt_count (tx_pkt_count)
`endif
  );

  always #3 clk_156m25 = ~clk_156m25;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  mod;
    logic [63:0] exp_d;
    logic [7:0]  exp_c;
    logic [63:0] nxt_d;
    logic [7:0]  nxt_c;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pkts_sent = 0;
  word_t       wq[$];
  logic [71:0] eq[$];
  bit          after_term;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] cur_col();
    return {xgmii_txc, xgmii_txd};
  endfunction

  task automatic tick();
    @(posedge clk_156m25);
    #1;
  endtask

  task automatic put(input logic [63:0] d, input logic s, input logic e, input logic [2:0] m);
    pkt_tx_data = d;
    pkt_tx_sop  = s;
    pkt_tx_eop  = e;
    pkt_tx_mod  = m;
    pkt_tx_val  = 1'b1;
  endtask

  task automatic idle_in();
    pkt_tx_val = 1'b0;
    pkt_tx_sop = 1'b0;
    pkt_tx_eop = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40; i++) begin
      if (cur_col() == {8'h01, START_D}) return;
      tick();
    end
    check(name, cur_col(), {8'h01, START_D});
  endtask

  task automatic count_nonidle(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (cur_col() != {8'hFF, IDLE_D}) n++;
    end
  endtask

  // Reference model: a packet is a byte stream; framing is START, the bytes,
  // an FD terminator and 07 padding to a column boundary, eight lanes per column.
  task automatic gen_packet(input bit gaps);
    int unsigned nw, nb, nd;
    logic [2:0]  m;
    logic [7:0]  bytes[$];
    word_t       w;
    logic [63:0] d;
    logic [7:0]  c;
    nw = $urandom_range(1, 6);
    m  = 3'($urandom_range(0, 7));
    if (gaps && ($urandom_range(3) == 0)) begin
      w = '{data: {$urandom, $urandom}, sop: 1'b0, eop: 1'b0, mod: 3'($urandom_range(0, 7))};
      wq.push_back(w);
    end
    for (int unsigned i = 0; i < nw; i++) begin
      w.data = {$urandom, $urandom};
      w.sop  = (i == 0) || ($urandom_range(7) == 0);
      w.eop  = (i == nw - 1);
      w.mod  = w.eop ? m : 3'($urandom_range(0, 7));
      wq.push_back(w);
      nb = (w.eop && (m != 3'd0)) ? 32'(m) : 8;
      for (int unsigned b = 0; b < nb; b++) bytes.push_back(w.data[63-8*b -: 8]);
    end
    nd = bytes.size();
    bytes.push_back(8'hFD);
    while ((bytes.size() % 8) != 0) bytes.push_back(8'h07);
    eq.push_back({8'h01, START_D});
    for (int unsigned col = 0; col < bytes.size() / 8; col++) begin
      for (int unsigned l = 0; l < 8; l++) begin
        d[8*l +: 8] = bytes[8*col + l];
        c[l]        = ((8*col + l) >= nd);
      end
      eq.push_back({c, d});
    end
    pkts_sent++;
  endtask

  task automatic monitor_col();
    logic [71:0] c;
    bit idle, term;
    c    = cur_col();
    idle = (c == {8'hFF, IDLE_D});
    term = 1'b0;
    for (int l = 0; l < 8; l++)
      if (c[64+l] && (c[8*l +: 8] == 8'hFD)) term = 1'b1;
    if (after_term) check("ipg_after_term", 72'(idle), 72'(1));
    if (!idle) begin
      if (eq.size() == 0) check("unexpected_col", c, {8'hFF, IDLE_D});
      else                check("stream_col", c, eq.pop_front());
    end
    after_term = term;
  endtask

  task automatic run_stream(input int npkts, input bit gaps);
    word_t w;
    int    cyc;
    after_term = 1'b0;
    for (int p = 0; p < npkts; p++) gen_packet(gaps);
    cyc = 0;
    while ((wq.size() > 0 || eq.size() > 0) && cyc < 4000) begin
      if (wq.size() > 0 && !pkt_tx_full && (!gaps || $urandom_range(3) != 0)) begin
        w = wq.pop_front();
        put(w.data, w.sop, w.eop, w.mod);
      end else begin
        idle_in();
      end
      tick();
      monitor_col();
      cyc++;
    end
    idle_in();
    for (int i = 0; i < 6; i++) begin
      tick();
      monitor_col();
    end
    check("stream_drain", 72'(eq.size()), 72'(0));
    eq.delete();
    wq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{64'hAABBCC0000000000, 3'd3, 64'h07070707FDCCBBAA, 8'hF8, IDLE_D, 8'hFF};
    vecs[1] = '{64'h0001020304050607, 3'd0, 64'h0706050403020100, 8'h00, TERM_D, 8'hFF};
    vecs[2] = '{64'h1122334455667788, 3'd1, 64'h070707070707FD11, 8'hFE, IDLE_D, 8'hFF};
    vecs[3] = '{64'h1122334455667788, 3'd7, 64'hFD77665544332211, 8'h80, IDLE_D, 8'hFF};
    vecs[4] = '{64'hDEADBEEFCAFEF00D, 3'd4, 64'h070707FDEFBEADDE, 8'hF0, IDLE_D, 8'hFF};
    vecs[5] = '{64'h0123456789ABCDEF, 3'd2, 64'h0707070707FD2301, 8'hFC, IDLE_D, 8'hFF};

    // Reset state
    tick(); tick();
    check("reset_col", cur_col(), {8'hFF, IDLE_D});
    check("reset_full", 72'(pkt_tx_full), 72'(0));
`ifdef MOD_PORT_STATS_EN
    check("reset_count", 72'(tx_pkt_count), 72'(0));
`endif
    reset_156m25 = 1'b0;
    tick();

    // Two-word packet with exact latency from the eop edge
    put(64'h0001020304050607, 1'b1, 1'b0, 3'd0);
    tick();
    put(64'h08090A0B0C0D0E0F, 1'b0, 1'b1, 3'd0);
    tick();
    idle_in();
    check("lat_e0_idle", cur_col(), {8'hFF, IDLE_D});
    tick(); check("lat_e1_idle", cur_col(), {8'hFF, IDLE_D});
    tick(); check("lat_e2_start", cur_col(), {8'h01, START_D});
    tick(); check("lat_e3_data0", cur_col(), {8'h00, 64'h0706050403020100});
    tick(); check("lat_e4_data1", cur_col(), {8'h00, 64'h0F0E0D0C0B0A0908});
    tick(); check("lat_e5_term", cur_col(), {8'hFF, TERM_D});
    tick(); check("lat_e6_idle", cur_col(), {8'hFF, IDLE_D});
    tick();

    // Single-word packets covering every terminate position
    for (int i = 0; i < 6; i++) begin
      put(vecs[i].data, 1'b1, 1'b1, vecs[i].mod);
      tick();
      idle_in();
      wait_start($sformatf("vec%0d_start", i));
      tick(); check($sformatf("vec%0d_eopcol", i), cur_col(), {vecs[i].exp_c, vecs[i].exp_d});
      tick(); check($sformatf("vec%0d_next", i), cur_col(), {vecs[i].nxt_c, vecs[i].nxt_d});
      tick(); tick(); tick();
    end

    // Words without sop are discarded while idle
    for (int i = 0; i < 3; i++) begin
      put(64'h1111111111111111 * 64'(i + 1), 1'b0, 1'b0, 3'd0);
      tick();
    end
    idle_in();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("junk_idle", cur_col(), {8'hFF, IDLE_D});
    end

    // Fill without a launchable packet; 17th write must be dropped
    for (int k = 1; k <= 17; k++) begin
      logic [7:0] b;
      b = 8'(k);
      put({8{b}}, (k == 1) || (k == 17), k >= 16, 3'd0);
      tick();
      check($sformatf("full_after_w%0d", k), 72'(pkt_tx_full), 72'(k >= 14));
    end
    idle_in();
    wait_start("full_start");
    for (int k = 1; k <= 16; k++) begin
      logic [7:0] b;
      b = 8'(k);
      tick();
      check($sformatf("full_data%0d", k), cur_col(), {8'h00, {8{b}}});
    end
    tick(); check("full_term", cur_col(), {8'hFF, TERM_D});
    count_nonidle(20, n);
    check("drop17_no_extra", 72'(n), 72'(0));
    check("full_cleared", 72'(pkt_tx_full), 72'(0));

    // Reset in the middle of a frame
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = 8'hA0 + 8'(k);
      put({8{b}}, k == 0, k == 3, 3'd0);
      tick();
    end
    idle_in();
    wait_start("rst_start");
    tick(); tick();
    #1 reset_156m25 = 1'b1;
    #1 check("rst_async_idle", cur_col(), {8'hFF, IDLE_D});
    check("rst_full", 72'(pkt_tx_full), 72'(0));
    tick();
    reset_156m25 = 1'b0;
    count_nonidle(10, n);
    check("rst_no_term", 72'(n), 72'(0));
`ifdef MOD_PORT_STATS_EN
    check("rst_count", 72'(tx_pkt_count), 72'(0));
`endif

    // Three back-to-back packets, then a randomized stream
    run_stream(3, 1'b0);
`ifdef MOD_PORT_STATS_EN
    check("count_3pkts", 72'(tx_pkt_count), 72'(3));
`endif
    run_stream(40, 1'b1);
`ifdef MOD_PORT_STATS_EN
    check("count_total", 72'(tx_pkt_count), 72'(pkts_sent));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
